rns_to_int_seq: RTL and testbench
=================================

Name: rns_to_int_seq

Overview:
- Multi-cycle, handshaked converter from a packed 4-residue RNS word back to a signed 32-bit integer.
- Uses mixed-radix conversion (MRC), so only small modular arithmetic is needed and there is no wide CRT modulo.
- Sits on the result path after RNS arithmetic units, in front of integer consumers.
- Output sign mapping uses the codebase-wide RNS_MIDDLE_POINT / INT_RNS_DELTA convention.

Parameters:
- B0, 233, modulus of rns[7:0]
- B1, 239, modulus of rns[15:8]
- B2, 241, modulus of rns[23:16]
- B3, 251, modulus of rns[31:24]
- Derived localparams:
  - M = B0*B1*B2*B3 = 3368562317
  - MIDDLE = (M+1)/2 = 1684281159
  - DELTA = 2^32 - M = 926404979
  - Modular inverses inv(Bi mod Bj), computed at elaboration by a constant function.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  rns word valid
- in_ready  out  1  block can accept a word
- rns  in  32  packed residues, r0 = [7:0] .. r3 = [31:24]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- int_number  out  32  signed integer result
- err  out  1  at least one residue was >= its modulus

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, int_number = 0, err = 0, all internal registers = 0.
- States and transitions:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch r0..r3, set a0 = r0, latch the err condition, go to D1.
  - D1: a1 = ((r1 - a0) * inv(B0,B1)) mod B1, go to D2.
  - D2: a2 = ((((r2 - a0) * inv(B0,B2)) - a1) * inv(B1,B2)) mod B2, go to D3.
  - D3: a3 computed the same way, Horner-style over a0..a2 with inverses mod B3, go to SUM.
  - SUM: X = a0 + a1*B0 + a2*B0*B1 + a3*B0*B1*B2, evaluated in 34 bits. X < M by construction. Register int_number = (X >= MIDDLE) ? X + DELTA (mod 2^32) : X. Assert out_valid. Go to OUT.
  - OUT: out_valid = 1; int_number and err held stable. On out_ready, out_valid drops at the next edge and the state returns to IDLE.
- Arithmetic rules:
  - Every subtraction is modular: add the target modulus before reducing so no intermediate goes negative.
  - Reductions operate on operands of 17 bits or fewer.
- Handshake and timing:
  - in_ready is high only in IDLE.
  - Accept at edge k gives out_valid = 1 after edge k+4; latency is 4 cycles.
  - Minimum initiation interval is 5 cycles with out_ready held at 1.
  - In OUT, in_valid is ignored and no input is consumed. in_ready is low, so the upstream must hold the word.
- Error path: if any ri >= Bi, err = 1 and int_number = 0, using the same timing. Digits are not meaningful in this case.
- Reset mid-operation: rst in any state returns to IDLE on that edge. Any in-flight result is discarded, out_valid = 0.
- rns is sampled only on the accept edge; changes at other times have no effect.

Test Plan:
- Reset, then rns = 0x00000000 accepted -> after 4 cycles out_valid = 1, int_number = 0, err = 0.
- rns = 0x05050505 -> int_number = 5.
- rns = 0xF7242C44 (residues 68, 44, 36, 247) -> int_number = 1000.
- rns = 0xFAF0EEE8 (residues M-1: 232, 238, 240, 250) -> int_number = 0xFFFFFFFF (-1).
- Sign boundary: residues of X = 1684281158 -> int_number = 1684281158. Residues of X = 1684281159 -> int_number = 2610686138 (signed -1684281158).
- Protocol cases, checked against a golden CRT model over 10k random valid words:
  - rns byte0 = 233 -> err = 1, int_number = 0.
  - out_ready held low for 10 cycles -> out_valid and int_number stable, in_ready = 0 throughout.
  - rst pulsed while in D2 -> next cycle in_ready = 1, out_valid = 0, and no output is ever produced for that word.

Source files
------------

// File: rtl/rns_to_int_seq.sv
// rtl/rns_to_int_seq.sv - multi-cycle mixed-radix conversion of a 4-residue RNS word to a signed 32-bit integer
module rns_to_int_seq #(
   parameter int unsigned B0 = 233,
   parameter int unsigned B1 = 239,
   parameter int unsigned B2 = 241,
   parameter int unsigned B3 = 251
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] rns,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] int_number,
   output logic        err
);

   function automatic int unsigned inv_mod(input int unsigned a, input int unsigned m);
      int unsigned r;
      r = 0;
      for (int unsigned x = 1; x < m; x++) begin
         if (((a % m) * x) % m == 1) r = x;
      end
      return r;
   endfunction

   localparam logic [33:0] M      = 34'(B0) * 34'(B1) * 34'(B2) * 34'(B3);
   localparam logic [33:0] MIDDLE = (M + 34'd1) >> 1;
   localparam logic [33:0] DELTA  = 34'h1_0000_0000 - M;
   localparam logic [33:0] W1     = 34'(B0);
   localparam logic [33:0] W2     = 34'(B0) * 34'(B1);
   localparam logic [33:0] W3     = 34'(B0) * 34'(B1) * 34'(B2);

   localparam logic [7:0] INV01 = 8'(inv_mod(B0, B1));
   localparam logic [7:0] INV02 = 8'(inv_mod(B0, B2));
   localparam logic [7:0] INV12 = 8'(inv_mod(B1, B2));
   localparam logic [7:0] INV03 = 8'(inv_mod(B0, B3));
   localparam logic [7:0] INV13 = 8'(inv_mod(B1, B3));
   localparam logic [7:0] INV23 = 8'(inv_mod(B2, B3));

   // One MRC step: ((t - sub) * inv) mod m, with m added first so the difference never goes negative.
   function automatic logic [7:0] mrc_step(input logic [7:0] t, input logic [7:0] sub,
                                           input logic [7:0] inv, input logic [8:0] m);
      logic [16:0] d;
      logic [16:0] p;
      d = (17'(t) + 17'(m) - 17'(sub)) % 17'(m);
      p = (d * 17'(inv)) % 17'(m);
      return 8'(p);
   endfunction

   typedef enum logic [2:0] {
      S_IDLE,
      S_D1,
      S_D2,
      S_D3,
      S_SUM,
      S_OUT
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  r1_q, r1_d;
   logic [7:0]  r2_q, r2_d;
   logic [7:0]  r3_q, r3_d;
   logic [7:0]  a0_q, a0_d;
   logic [7:0]  a1_q, a1_d;
   logic [7:0]  a2_q, a2_d;
   logic [7:0]  a3_q, a3_d;
   logic        err_q, err_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] int_number_q, int_number_d;
   logic [33:0] x_sum;
   logic [31:0] x_mapped;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         r1_q         <= '0;
         r2_q         <= '0;
         r3_q         <= '0;
         a0_q         <= '0;
         a1_q         <= '0;
         a2_q         <= '0;
         a3_q         <= '0;
         err_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         int_number_q <= '0;
      end else begin
         state_q      <= state_d;
         r1_q         <= r1_d;
         r2_q         <= r2_d;
         r3_q         <= r3_d;
         a0_q         <= a0_d;
         a1_q         <= a1_d;
         a2_q         <= a2_d;
         a3_q         <= a3_d;
         err_q        <= err_d;
         out_valid_q  <= out_valid_d;
         int_number_q <= int_number_d;
      end
   end

   // Mixed-radix digits recombine to X < M; the upper half of [0, M) maps to negative integers.
   always_comb begin
      x_sum    = 34'(a0_q) + 34'(a1_q) * W1 + 34'(a2_q) * W2 + 34'(a3_q) * W3;
      x_mapped = (x_sum >= MIDDLE) ? 32'(x_sum + DELTA) : 32'(x_sum);
   end

   always_comb begin
      state_d      = state_q;
      r1_d         = r1_q;
      r2_d         = r2_q;
      r3_d         = r3_q;
      a0_d         = a0_q;
      a1_d         = a1_q;
      a2_d         = a2_q;
      a3_d         = a3_q;
      err_d        = err_q;
      out_valid_d  = out_valid_q;
      int_number_d = int_number_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a0_d    = rns[7:0];
               r1_d    = rns[15:8];
               r2_d    = rns[23:16];
               r3_d    = rns[31:24];
               err_d   = ({1'b0, rns[7:0]}   >= 9'(B0)) ||
                         ({1'b0, rns[15:8]}  >= 9'(B1)) ||
                         ({1'b0, rns[23:16]} >= 9'(B2)) ||
                         ({1'b0, rns[31:24]} >= 9'(B3));
               state_d = S_D1;
            end
         end
         S_D1: begin
            a1_d    = mrc_step(r1_q, a0_q, INV01, 9'(B1));
            state_d = S_D2;
         end
         S_D2: begin
            a2_d    = mrc_step(mrc_step(r2_q, a0_q, INV02, 9'(B2)), a1_q, INV12, 9'(B2));
            state_d = S_D3;
         end
         S_D3: begin
            a3_d    = mrc_step(mrc_step(mrc_step(r3_q, a0_q, INV03, 9'(B3)),
                                        a1_q, INV13, 9'(B3)),
                               a2_q, INV23, 9'(B3));
            state_d = S_SUM;
         end
         S_SUM: begin
            int_number_d = err_q ? 32'd0 : x_mapped;
            out_valid_d  = 1'b1;
            state_d      = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = out_valid_q;
   assign int_number = int_number_q;
   assign err        = err_q;

endmodule

// File: tb/tb_rns_to_int_seq.sv
// tb/tb_rns_to_int_seq.sv - self-checking bench for rns_to_int_seq against a CRT reference
module tb_rns_to_int_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] rns;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] int_number;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   longint unsigned bm[4];
   longint unsigned mi[4];
   longint unsigned yi[4];
   longint unsigned m_all;

   typedef struct {
      logic [31:0] rns;
      logic [31:0] exp_int;
      logic        exp_err;
      int          hold;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   rns_to_int_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rns        (rns),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .int_number (int_number),
      .err        (err)
   );

   function automatic logic [31:0] map_signed(input longint unsigned x);
      if (x >= (m_all + 1) / 2) return 32'(x + (64'h1_0000_0000 - m_all));
      return 32'(x);
   endfunction

   function automatic logic [31:0] to_rns(input longint unsigned x);
      return {8'(x % bm[3]), 8'(x % bm[2]), 8'(x % bm[1]), 8'(x % bm[0])};
   endfunction

   // Chinese remainder theorem: X = sum(r_i * M_i * (M_i^-1 mod B_i)) mod M.
   function automatic logic [31:0] golden(input logic [31:0] w);
      longint unsigned s;
      s = 0;
      for (int i = 0; i < 4; i++) s += 64'(w[8*i +: 8]) * mi[i] * yi[i];
      return map_signed(s % m_all);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic apply(input string name, input logic [31:0] w, input logic [31:0] exp_int,
                        input logic exp_err, input int hold);
      int lat;
      @(negedge clk);
      chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      rns      = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rns      = $urandom;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) break;
      end
      chk({name, ".latency"}, 32'(lat), 32'd4);
      if (!out_valid) return;
      chk({name, ".int_number"}, int_number, exp_int);
      chk({name, ".err"}, 32'(err), 32'(exp_err));
      if (hold > 0) begin
         out_ready = 1'b0;
         for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1;
            rns      = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk({name, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, ".hold_int"}, int_number, exp_int);
            chk({name, ".hold_err"}, 32'(err), 32'(exp_err));
            chk({name, ".hold_in_ready"}, 32'(in_ready), 32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk({name, ".post_valid"}, 32'(out_valid), 32'd0);
      chk({name, ".post_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] w;
      int          lane;
      int          hold;
      int          seen;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rns       = '0;
      bm        = '{64'd233, 64'd239, 64'd241, 64'd251};
      m_all     = bm[0] * bm[1] * bm[2] * bm[3];
      for (int i = 0; i < 4; i++) begin
         mi[i] = m_all / bm[i];
         yi[i] = 0;
         for (longint unsigned y = 1; y < bm[i]; y++)
            if (((mi[i] % bm[i]) * y) % bm[i] == 1) yi[i] = y;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.int_number", int_number, 32'd0);
      chk("reset.err", 32'(err), 32'd0);
      rst = 1'b0;

      vecs[0] = '{32'h0000_0000, 32'd0,          1'b0, 0};
      vecs[1] = '{32'h0505_0505, 32'd5,          1'b0, 0};
      vecs[2] = '{32'hF724_2C44, 32'd1000,       1'b0, 10};
      vecs[3] = '{32'hFAF0_EEE8, 32'hFFFF_FFFF,  1'b0, 0};
      vecs[4] = '{to_rns(64'd1684281158), 32'd1684281158, 1'b0, 0};
      vecs[5] = '{to_rns(64'd1684281159), 32'd2610686138, 1'b0, 2};
      vecs[6] = '{32'h0000_00E9, 32'd0,          1'b1, 0};
      vecs[7] = '{32'hFB00_0000, 32'd0,          1'b1, 3};
      for (int i = 0; i < 8; i++)
         apply($sformatf("vec%0d", i), vecs[i].rns, vecs[i].exp_int, vecs[i].exp_err, vecs[i].hold);

      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'($urandom_range(0, 32'(bm[i]) - 1));
         hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
         if ($urandom_range(0, 15) == 0) begin
            lane = int'($urandom_range(0, 3));
            w[8*lane +: 8] = 8'($urandom_range(32'(bm[lane]), 255));
            apply("rand_err", w, 32'd0, 1'b1, hold);
         end else begin
            apply("rand", w, golden(w), 1'b0, hold);
         end
      end

      apply("pre_rst", 32'hF724_2C44, 32'd1000, 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b1;
      rns      = 32'h0505_0505;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst.int_number", int_number, 32'd0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("mid_rst.no_output", 32'(seen), 32'd0);
      apply("post_rst", 32'hF724_2C44, 32'd1000, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
